// File: rtl/spike_argmax.sv
// spike_argmax: snapshot, verify and serially scan spike counts for the winner.
// Optional: SPIKE_ARGMAX_RETRY_LIMIT_EN bounds snapshot retries and drives err.
module spike_argmax #(
  parameter int NUM_INPUTS   = 10,
  parameter int COUNTER_SIZE = 4,
  parameter int IDX_W        =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_INPUTS*COUNTER_SIZE-1:0] counts_in,
  output logic                               busy,
  output logic                               done,
  output logic [IDX_W-1:0]                   winner_idx,
  output logic [COUNTER_SIZE-1:0]            winner_count,
  output logic                               tie,
  output logic                               no_spike,
  output logic                               err,
  output logic                               clear_counters
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_VERIFY,
    S_SCAN,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

  typedef logic [NUM_INPUTS-1:0][COUNTER_SIZE-1:0] snap_t;

  state_e                  state_q, state_d;
  snap_t                   snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [COUNTER_SIZE-1:0] max_q, max_d;
  logic [IDX_W-1:0]        max_idx_q, max_idx_d;
  logic                    run_tie_q, run_tie_d;
  logic [IDX_W-1:0]        win_idx_q, win_idx_d;
  logic [COUNTER_SIZE-1:0] win_cnt_q, win_cnt_d;
  logic                    win_tie_q, win_tie_d;
  logic                    no_spike_q, no_spike_d;

  logic [COUNTER_SIZE-1:0] cur;
  logic [COUNTER_SIZE-1:0] s_max;
  logic [IDX_W-1:0]        s_idx;
  logic                    s_tie;

`ifdef SPIKE_ARGMAX_RETRY_LIMIT_EN
  logic [2:0] retry_q, retry_d;
  logic       err_q, err_d;
`endif

  // Running-max update for the neuron currently under the scan pointer
  always_comb begin
    cur   = snap_q[idx_q];
    s_max = max_q;
    s_idx = max_idx_q;
    s_tie = run_tie_q;
    if (cur > max_q) begin
      s_max = cur;
      s_idx = idx_q;
      s_tie = 1'b0;
    end else if (cur == max_q && idx_q != '0) begin
      s_tie = 1'b1;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    run_tie_d  = run_tie_q;
    win_idx_d  = win_idx_q;
    win_cnt_d  = win_cnt_q;
    win_tie_d  = win_tie_q;
    no_spike_d = no_spike_q;
`ifdef SPIKE_ARGMAX_RETRY_LIMIT_EN
    retry_d    = retry_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
`ifdef SPIKE_ARGMAX_RETRY_LIMIT_EN
          retry_d = 3'd0;
          err_d   = 1'b0;
`endif
        end
      end
      S_CAPTURE: begin
        snap_d  = counts_in;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (counts_in == snap_q) begin
          state_d   = S_SCAN;
          idx_d     = '0;
          max_d     = '0;
          max_idx_d = '0;
          run_tie_d = 1'b0;
        end else begin
`ifdef SPIKE_ARGMAX_RETRY_LIMIT_EN
          if (retry_q == 3'd3) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = S_CAPTURE;
          end
`else
          state_d = S_CAPTURE;
`endif
        end
      end
      S_SCAN: begin
        max_d     = s_max;
        max_idx_d = s_idx;
        run_tie_d = s_tie;
        if (idx_q == LAST) begin
          // an all-zero window is "no spike", never a tie
          win_idx_d  = s_idx;
          win_cnt_d  = s_max;
          win_tie_d  = s_tie && (s_max != '0);
          no_spike_d = (s_max == '0);
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      run_tie_q  <= 1'b0;
      win_idx_q  <= '0;
      win_cnt_q  <= '0;
      win_tie_q  <= 1'b0;
      no_spike_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      run_tie_q  <= run_tie_d;
      win_idx_q  <= win_idx_d;
      win_cnt_q  <= win_cnt_d;
      win_tie_q  <= win_tie_d;
      no_spike_q <= no_spike_d;
    end
  end

`ifdef SPIKE_ARGMAX_RETRY_LIMIT_EN
  // Retry bookkeeping for unstable snapshots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign clear_counters = (state_q == S_DONE);
  assign winner_idx     = win_idx_q;
  assign winner_count   = win_cnt_q;
  assign tie            = win_tie_q;
  assign no_spike       = no_spike_q;

endmodule

// File: doc/spike_argmax.md
Name: spike_argmax

Overview:
- Classification stage directly downstream of the asynchronous spike counter bank.
- On a start request it snapshots the concatenated per-neuron spike counts and confirms the snapshot is stable against the asynchronous counters.
- It then scans one neuron per clock and reports the index and count of the neuron with the most spikes.
- It pulses a counter-clear output so the next inference window starts from zero.

Parameters:
- NUM_INPUTS, 10, number of neurons/counters feeding the block.
- COUNTER_SIZE, 4, width of each spike count.
- IDX_W, $clog2(NUM_INPUTS) (minimum 1), width of the winner index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a classification; sampled only in IDLE.
- counts_in  input  NUM_INPUTS*COUNTER_SIZE  concatenated counts; neuron i occupies bits [(i+1)*COUNTER_SIZE-1 : i*COUNTER_SIZE].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results update.
- winner_idx  output  IDX_W  index of the maximum count.
- winner_count  output  COUNTER_SIZE  the maximum count value.
- tie  output  1  another neuron equals the maximum.
- no_spike  output  1  all counts are zero.
- err  output  1  snapshot never stabilised (optional feature only).
- clear_counters  output  1  one-cycle pulse to reset the upstream counters.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state forced to IDLE.
  - all outputs 0, including busy, done and clear_counters.
  - snapshot, running max and index registers cleared.
  - no partial result is ever published.
- FSM states: IDLE, CAPTURE, VERIFY, SCAN, DONE.
- IDLE: start=1 at edge E0 moves to CAPTURE. busy rises after E0.
- CAPTURE: at E1, register counts_in into snap and go to VERIFY.
- VERIFY: at E2, compare live counts_in with snap.
  - Equal: go to SCAN, idx=0, max=0, max_idx=0, tie=0.
  - Unequal: go back to CAPTURE (resample).
- SCAN, one neuron per edge, using snap[idx] only (never the live input):
  - snap[idx] > max: max=snap[idx], max_idx=idx, tie=0.
  - snap[idx] == max and idx != 0: tie=1.
  - On the idx=NUM_INPUTS-1 edge: latch winner_idx=max_idx, winner_count=max, tie, no_spike=(max==0); go to DONE.
- DONE: done=1 and clear_counters=1 for exactly this one cycle; busy=1. Next edge returns to IDLE.
- Latency with no resample: done is high in the cycle after edge E(NUM_INPUTS+2). With NUM_INPUTS=10, that is after E12.
- Each VERIFY mismatch adds 2 cycles.
- Ties: the lowest index wins.
- All zero: winner_idx=0, winner_count=0, no_spike=1, tie=0.
- Result outputs hold their values until the next DONE.
- start while busy is ignored. It is not queued.
- start held high continuously re-triggers from IDLE, i.e. one cycle after DONE.
- Comparisons are unsigned, COUNTER_SIZE bits. Saturated or wrapped upstream counts are compared as-is.

Optional Feature:
- Macro: SPIKE_ARGMAX_RETRY_LIMIT_EN.
- Defined:
  - A 3-bit retry counter is cleared on start acceptance and incremented on each VERIFY mismatch.
  - The 4th consecutive mismatch goes to DONE with err=1; winner_idx, winner_count, tie and no_spike keep their previous values.
  - clear_counters still pulses.
  - err clears on the next start acceptance.
- Undefined: retries are unbounded and err is tied to 0.

Test Plan:
- Reset mid-SCAN: drop rst at cycle 6 after start -> busy, done and all results 0 immediately; state IDLE; no done pulse after rst releases.
- NUM_INPUTS=10, counts {3,7,2,9,0,1,9,4,5,6}, stable; start pulse -> done exactly 12 edges after the start edge; winner_idx=3, winner_count=9, tie=1, no_spike=0; clear_counters pulses with done.
- All counts zero; start -> winner_idx=0, winner_count=0, no_spike=1, tie=0.
- Single maximum 15 at index 9, others 1 -> winner_idx=9, winner_count=15, tie=0.
- counts_in changes between CAPTURE and VERIFY once -> one resample; done at edge 14; result reflects the new values.
- start pulsed again during SCAN -> ignored; one done only. With SPIKE_ARGMAX_RETRY_LIMIT_EN and counts_in toggling every cycle -> done with err=1 after 4 mismatches; previous results unchanged.
